// File: rtl/mayor_cmp.sv
// Registered unsigned magnitude comparator (GT/EQ/LT flags plus larger operand).
// Define MAYOR_CMP_COMB_EN to add the zero-latency combinational output F_c.
module mayor_cmp #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             F,
  output logic             EQ,
  output logic             LT,
  output logic [WIDTH-1:0] MAX,
`ifdef MAYOR_CMP_COMB_EN
  output logic             out_valid,
  output logic             F_c
`else
  output logic             out_valid
`endif
);

  logic             f_q, f_d;
  logic             eq_q, eq_d;
  logic             lt_q, lt_d;
  logic [WIDTH-1:0] max_q, max_d;
  logic             out_valid_q, out_valid_d;
  logic             gt_s, eq_s;

  assign gt_s = (A > B);
  assign eq_s = (A == B);

  // Next-state: capture a fresh result on accepted samples, otherwise hold.
  always_comb begin
    f_d         = f_q;
    eq_d        = eq_q;
    lt_d        = lt_q;
    max_d       = max_q;
    out_valid_d = in_valid;
    if (in_valid) begin
      f_d   = gt_s;
      eq_d  = eq_s;
      lt_d  = ~(gt_s | eq_s);
      max_d = (gt_s | eq_s) ? A : B;
    end else begin
      f_d   = f_q;
      eq_d  = eq_q;
      lt_d  = lt_q;
      max_d = max_q;
    end
  end

  // Output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_q         <= 1'b0;
      eq_q        <= 1'b0;
      lt_q        <= 1'b0;
      max_q       <= {WIDTH{1'b0}};
      out_valid_q <= 1'b0;
    end else begin
      f_q         <= f_d;
      eq_q        <= eq_d;
      lt_q        <= lt_d;
      max_q       <= max_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign F         = f_q;
  assign EQ        = eq_q;
  assign LT        = lt_q;
  assign MAX       = max_q;
  assign out_valid = out_valid_q;

`ifdef MAYOR_CMP_COMB_EN
  assign F_c = gt_s;
`endif

endmodule

// File: tb/tb_mayor_cmp.sv
// Self-checking bench for mayor_cmp: directed vectors, exhaustive, random, reset cases.
module tb_mayor_cmp;
  localparam int W = 3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] a, b;
  logic         f, eq, lt, ov;
  logic [W-1:0] mx;
`ifdef MAYOR_CMP_COMB_EN
  logic         f_c;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference model state: last accepted result, as plain integers.
  int m_f, m_eq, m_lt, m_max, m_ov;
  bit seen;

  always #5 clk = ~clk;

  mayor_cmp #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .A         (a),
    .B         (b),
    .F         (f),
    .EQ        (eq),
    .LT        (lt),
    .MAX       (mx),
`ifdef MAYOR_CMP_COMB_EN
    .out_valid (ov),
    .F_c       (f_c)
`else
    .out_valid (ov)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_f = 0; m_eq = 0; m_lt = 0; m_max = 0; m_ov = 0; seen = 1'b0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".F"},   {31'd0, f},  m_f);
    chk({tag, ".EQ"},  {31'd0, eq}, m_eq);
    chk({tag, ".LT"},  {31'd0, lt}, m_lt);
    chk({tag, ".MAX"}, {29'd0, mx}, m_max);
    chk({tag, ".VLD"}, {31'd0, ov}, m_ov);
    chk({tag, ".ONEHOT"}, $countones({f, eq, lt}), seen ? 1 : 0);
  endtask

  // Drive one sample, advance one edge, update model, compare.
  task automatic cycle(input string tag, input bit v, input int av, input int bv);
    in_valid = v;
    a = av[W-1:0];
    b = bv[W-1:0];
    @(posedge clk);
    #1;
    if (rst_n) begin
      m_ov = v ? 1 : 0;
      if (v) begin
        m_f   = (av > bv)  ? 1 : 0;
        m_eq  = (av == bv) ? 1 : 0;
        m_lt  = (av < bv)  ? 1 : 0;
        m_max = (av >= bv) ? av : bv;
        seen  = 1'b1;
      end
    end else begin
      model_clear();
    end
    check_all(tag);
  endtask

  int va[8] = '{0, 1, 2, 3, 4, 5, 4, 3};
  int vb[8] = '{1, 0, 3, 2, 4, 5, 5, 0};

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b1;
    a = '0;
    b = '0;
    model_clear();

    // Reset held with random operands.
    for (int i = 0; i < 2; i++) begin
      cycle("reset", 1'b1, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
    end
    rst_n = 1'b1;

    // Directed vectors.
    for (int i = 0; i < 8; i++) cycle("vec", 1'b1, va[i], vb[i]);

    // Hold when in_valid is low.
    cycle("hold_acc", 1'b1, 3, 0);
    cycle("hold", 1'b0, 0, 7);
    cycle("hold2", 1'b0, 6, 1);

    // Boundaries.
    cycle("bnd_max", 1'b1, 7, 0);
    cycle("bnd_min", 1'b1, 0, 7);

    // Exhaustive pairs.
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        cycle("exh", 1'b1, i, j);

    // Random traffic with random valid.
    for (int i = 0; i < 60; i++)
      cycle("rnd", bit'($urandom_range(0, 1)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));

    // Async reset between edges.
    cycle("pre_rst", 1'b1, 5, 2);
    #2;
    rst_n = 1'b0;
    #1;
    model_clear();
    check_all("async_rst");
    cycle("rst_low", 1'b1, 6, 1);
    #2;
    rst_n = 1'b1;
    cycle("post_rst_hold", 1'b0, 6, 1);
    cycle("post_rst", 1'b1, 2, 6);

    // Combinational output check (F_c only exists in that build).
    cycle("comb_pre", 1'b1, 0, 0);
    in_valid = 1'b1;
    a = 3'd5;
    b = 3'd4;
    #1;
`ifdef MAYOR_CMP_COMB_EN
    chk("comb.F_c", {31'd0, f_c}, 1);
`endif
    chk("comb.F_before", {31'd0, f}, 0);
    cycle("comb_edge", 1'b1, 5, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
